// File: rtl/bht_pkg.sv
// Shared constants, entry layout and FSM encoding for the BHT write side.
// Optional build macro: BHT_STATS_EN (update/mispredict counters).
package bht_pkg;

    localparam int SETS  = 16;
    localparam int WAYS  = 4;
    localparam int TAG_W = 6;
    localparam int TGT_W = 10;
    localparam int ENT_W = 19;

    localparam int E_VALID  = 18;
    localparam int E_TAG_HI = 17;
    localparam int E_TAG_LO = 12;
    localparam int E_TGT_HI = 11;
    localparam int E_TGT_LO = 2;
    localparam int E_CTR_HI = 1;
    localparam int E_CTR_LO = 0;

    localparam logic [1:0] CTR_INIT_JUMP = 2'b11;
    localparam logic [1:0] CTR_INIT_BR   = 2'b10;

    typedef enum logic {
        S_CLEAR = 1'b0,
        S_RUN   = 1'b1
    } state_t;

    function automatic logic [ENT_W-1:0] mk_entry(
        input logic [TAG_W-1:0] tag,
        input logic [TGT_W-1:0] tgt,
        input logic [1:0]       ctr
    );
        return {1'b1, tag, tgt, ctr};
    endfunction

endpackage

// File: rtl/bht_sat_ctr.sv
// 2-bit saturating counter step, shared with the predictor-side logic.
// Optional build macro: none.
module bht_sat_ctr (
    input  logic [1:0] i_ctr,
    input  logic       i_taken,
    output logic [1:0] o_ctr
);

    always_comb begin
        o_ctr = i_ctr;
        if (i_taken && (i_ctr != 2'b11))
            o_ctr = i_ctr + 2'd1;
        else if (!i_taken && (i_ctr != 2'b00))
            o_ctr = i_ctr - 2'd1;
    end

endmodule

// File: rtl/bht_update_ctrl.sv
// BHT write-port controller: clear sweep, update/alloc arbitration, FIFO replacement.
// Optional build macro: BHT_STATS_EN adds stat_upd / stat_mispred outputs.
module bht_update_ctrl
    import bht_pkg::*;
(
    input  logic             CLK,
    input  logic             rst,
    input  logic             inv_req,
    input  logic             alloc_req,
    input  logic [9:0]       alloc_pc,
    input  logic [9:0]       alloc_target,
    input  logic             alloc_is_jump,
    input  logic             upd_req,
    input  logic [5:0]       upd_idx,
    input  logic [ENT_W-1:0] upd_entry,
    input  logic             upd_taken,
    output logic             wr_en,
    output logic [5:0]       wr_addr,
    output logic [ENT_W-1:0] wr_data,
    output logic             ready,
`ifdef BHT_STATS_EN
    output logic [15:0]      stat_upd,
    output logic [15:0]      stat_mispred,
`endif
    output logic             alloc_drop
);

    state_t           r_state;
    logic [6:0]       r_clr_idx;
    logic [1:0]       r_fifo_ptr [SETS];
    logic             r_pend_v;
    logic [9:0]       r_pend_pc;
    logic [9:0]       r_pend_tgt;
    logic             r_pend_jump;

    logic [1:0]       w_upd_ctr;
    logic [ENT_W-1:0] w_upd_data;
    logic [9:0]       w_al_pc;
    logic [9:0]       w_al_tgt;
    logic             w_al_jump;
    logic [3:0]       w_al_set;
    logic [1:0]       w_al_way;
    logic [ENT_W-1:0] w_al_data;
    logic             w_merge;

    bht_sat_ctr u_sat_ctr (
        .i_ctr   (upd_entry[E_CTR_HI:E_CTR_LO]),
        .i_taken (upd_taken),
        .o_ctr   (w_upd_ctr)
    );

    assign w_upd_data = {upd_entry[E_VALID:E_TGT_LO], w_upd_ctr};

    // A waiting allocation always goes ahead of a fresh one.
    assign w_al_pc   = r_pend_v ? r_pend_pc   : alloc_pc;
    assign w_al_tgt  = r_pend_v ? r_pend_tgt  : alloc_target;
    assign w_al_jump = r_pend_v ? r_pend_jump : alloc_is_jump;
    assign w_al_set  = w_al_pc[3:0];
    assign w_al_way  = r_fifo_ptr[w_al_set];
    assign w_al_data = mk_entry(w_al_pc[9:4], w_al_tgt,
                                w_al_jump ? CTR_INIT_JUMP : CTR_INIT_BR);
    assign w_merge   = r_pend_v && (alloc_pc == r_pend_pc);

    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            r_state     <= S_CLEAR;
            r_clr_idx   <= '0;
            r_pend_v    <= 1'b0;
            r_pend_pc   <= '0;
            r_pend_tgt  <= '0;
            r_pend_jump <= 1'b0;
            for (int s = 0; s < SETS; s++) r_fifo_ptr[s] <= '0;
            wr_en       <= 1'b0;
            wr_addr     <= '0;
            wr_data     <= '0;
            ready       <= 1'b0;
            alloc_drop  <= 1'b0;
`ifdef BHT_STATS_EN
            stat_upd     <= '0;
            stat_mispred <= '0;
`endif
        end else begin
            wr_en      <= 1'b0;
            alloc_drop <= 1'b0;
            unique case (r_state)
                S_CLEAR: begin
                    if (inv_req) begin
                        r_clr_idx <= '0;
`ifdef BHT_STATS_EN
                        stat_upd     <= '0;
                        stat_mispred <= '0;
`endif
                    end else if (r_clr_idx[6]) begin
                        ready   <= 1'b1;
                        r_state <= S_RUN;
                    end else begin
                        wr_en     <= 1'b1;
                        wr_addr   <= r_clr_idx[5:0];
                        wr_data   <= '0;
                        r_clr_idx <= r_clr_idx + 7'd1;
                    end
                end
                S_RUN: begin
                    if (inv_req) begin
                        r_state   <= S_CLEAR;
                        r_clr_idx <= '0;
                        r_pend_v  <= 1'b0;
                        ready     <= 1'b0;
                        for (int s = 0; s < SETS; s++) r_fifo_ptr[s] <= '0;
`ifdef BHT_STATS_EN
                        stat_upd     <= '0;
                        stat_mispred <= '0;
`endif
                    end else if (upd_req) begin
                        wr_en   <= 1'b1;
                        wr_addr <= upd_idx;
                        wr_data <= w_upd_data;
`ifdef BHT_STATS_EN
                        if (stat_upd != 16'hFFFF)
                            stat_upd <= stat_upd + 16'd1;
                        if ((upd_entry[E_CTR_HI] != upd_taken) &&
                            (stat_mispred != 16'hFFFF))
                            stat_mispred <= stat_mispred + 16'd1;
`endif
                        if (alloc_req && !w_merge) begin
                            if (!r_pend_v) begin
                                r_pend_v    <= 1'b1;
                                r_pend_pc   <= alloc_pc;
                                r_pend_tgt  <= alloc_target;
                                r_pend_jump <= alloc_is_jump;
                            end else begin
                                alloc_drop <= 1'b1;
                            end
                        end
                    end else if (r_pend_v || alloc_req) begin
                        wr_en                <= 1'b1;
                        wr_addr              <= {w_al_set, w_al_way};
                        wr_data              <= w_al_data;
                        r_fifo_ptr[w_al_set] <= w_al_way + 2'd1;
                        r_pend_v             <= 1'b0;
                        // Draining the buffer frees it for a distinct fresh request.
                        if (r_pend_v && alloc_req && !w_merge) begin
                            r_pend_v    <= 1'b1;
                            r_pend_pc   <= alloc_pc;
                            r_pend_tgt  <= alloc_target;
                            r_pend_jump <= alloc_is_jump;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bht_update_ctrl.sv
// Directed bench for bht_update_ctrl: clear sweep, FIFO alloc, updates, arbitration.
// Optional build macro: BHT_STATS_EN enables the statistics checks.
module tb_bht_update_ctrl;

    logic        CLK = 1'b0;
    logic        rst = 1'b1;
    logic        inv_req = 1'b0;
    logic        alloc_req = 1'b0;
    logic [9:0]  alloc_pc = '0;
    logic [9:0]  alloc_target = '0;
    logic        alloc_is_jump = 1'b0;
    logic        upd_req = 1'b0;
    logic [5:0]  upd_idx = '0;
    logic [18:0] upd_entry = '0;
    logic        upd_taken = 1'b0;
    logic        wr_en;
    logic [5:0]  wr_addr;
    logic [18:0] wr_data;
    logic        ready;
    logic        alloc_drop;
`ifdef BHT_STATS_EN
    logic [15:0] stat_upd;
    logic [15:0] stat_mispred;
`endif

    int n_chk  = 0;
    int n_pass = 0;

    bht_update_ctrl dut (
        .CLK           (CLK),
        .rst           (rst),
        .inv_req       (inv_req),
        .alloc_req     (alloc_req),
        .alloc_pc      (alloc_pc),
        .alloc_target  (alloc_target),
        .alloc_is_jump (alloc_is_jump),
        .upd_req       (upd_req),
        .upd_idx       (upd_idx),
        .upd_entry     (upd_entry),
        .upd_taken     (upd_taken),
        .wr_en         (wr_en),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .ready         (ready),
`ifdef BHT_STATS_EN
        .stat_upd      (stat_upd),
        .stat_mispred  (stat_mispred),
`endif
        .alloc_drop    (alloc_drop)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [18:0] ent(input logic [5:0] tag,
                                        input logic [9:0] tgt,
                                        input logic [1:0] ctr);
        return {1'b1, tag, tgt, ctr};
    endfunction

    task automatic sweep(input string tag);
        for (int i = 0; i < 64; i++) begin
            tick();
            chk(tag, 32'({ready, wr_en, wr_addr, wr_data}),
                32'({1'b0, 1'b1, i[5:0], 19'd0}));
            if (i == 2) begin
                @(negedge CLK);
                alloc_req = 1'b0;
                upd_req   = 1'b0;
            end
        end
        tick();
        chk({tag, "_rdy"}, 32'({ready, wr_en}), 32'({1'b1, 1'b0}));
    endtask

    logic [9:0] al_pc   [5] = '{10'h013, 10'h023, 10'h033, 10'h043, 10'h053};
    logic       al_jmp  [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [5:0] al_addr [5] = '{6'd12, 6'd13, 6'd14, 6'd15, 6'd12};
    logic [1:0] al_ctr  [5] = '{2'b10, 2'b10, 2'b11, 2'b10, 2'b10};

    logic [1:0] u_ctr [5] = '{2'd3, 2'd0, 2'd1, 2'd2, 2'd3};
    logic       u_tk  [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [1:0] u_exp [5] = '{2'd3, 2'd0, 2'd2, 2'd1, 2'd3};

    initial begin
        #1;
        chk("rst_out", 32'({wr_en, wr_addr, wr_data, ready, alloc_drop}), 32'd0);
        @(negedge CLK);
        rst = 1'b0;
        // Requests during the sweep must be ignored, not queued.
        alloc_req = 1'b1;
        alloc_pc  = 10'h0A3;
        upd_req   = 1'b1;
        sweep("clr");
        tick();
        chk("no_queued", 32'(wr_en), 32'd0);

        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            alloc_req     = 1'b1;
            alloc_pc      = al_pc[i];
            alloc_target  = al_pc[i] + 10'h100;
            alloc_is_jump = al_jmp[i];
            tick();
            chk("al_addr", 32'({wr_en, wr_addr}), 32'({1'b1, al_addr[i]}));
            chk("al_data", 32'(wr_data),
                32'(ent(al_pc[i][9:4], al_pc[i] + 10'h100, al_ctr[i])));
        end
        @(negedge CLK);
        alloc_req = 1'b0;
        tick();
        chk("al_idle", 32'(wr_en), 32'd0);

        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            upd_req   = 1'b1;
            upd_idx   = 6'(12 + i);
            upd_entry = ent(6'h01, 10'h155, u_ctr[i]);
            upd_taken = u_tk[i];
            tick();
            chk("upd_addr", 32'({wr_en, wr_addr}), 32'({1'b1, 6'(12 + i)}));
            chk("upd_data", 32'(wr_data), 32'(ent(6'h01, 10'h155, u_exp[i])));
        end

        // Update + alloc together: alloc waits, second alloc is dropped.
        @(negedge CLK);
        upd_idx = 6'd7; upd_entry = ent(6'h02, 10'h0AA, 2'd2); upd_taken = 1'b1;
        alloc_req = 1'b1; alloc_pc = 10'h045; alloc_target = 10'h3C0;
        alloc_is_jump = 1'b0;
        tick();
        chk("cc_upd", 32'({wr_en, wr_addr, wr_data, alloc_drop}),
            32'({1'b1, 6'd7, ent(6'h02, 10'h0AA, 2'd3), 1'b0}));
        @(negedge CLK);
        upd_idx = 6'd8; upd_entry = ent(6'h03, 10'h011, 2'd1); upd_taken = 1'b0;
        alloc_pc = 10'h051; alloc_target = 10'h111;
        tick();
        chk("cc_upd2", 32'({wr_en, wr_addr, wr_data}),
            32'({1'b1, 6'd8, ent(6'h03, 10'h011, 2'd0)}));
        chk("cc_drop", 32'(alloc_drop), 32'd1);
        @(negedge CLK);
        upd_req = 1'b0; alloc_req = 1'b0;
        tick();
        chk("cc_pend", 32'({wr_en, wr_addr, alloc_drop}), 32'({1'b1, 6'd20, 1'b0}));
        chk("cc_pdat", 32'(wr_data), 32'(ent(6'h04, 10'h3C0, 2'b10)));
        tick();
        chk("cc_idle", 32'(wr_en), 32'd0);

        // Same-pc request while pending is merged silently.
        @(negedge CLK);
        upd_req = 1'b1; upd_idx = 6'd1; upd_entry = ent(6'h00, 10'h001, 2'd1);
        alloc_req = 1'b1; alloc_pc = 10'h062; alloc_target = 10'h222;
        alloc_is_jump = 1'b1;
        tick();
        @(negedge CLK);
        tick();
        chk("mg_nodrop", 32'({wr_en, wr_addr, alloc_drop}), 32'({1'b1, 6'd1, 1'b0}));
        @(negedge CLK);
        upd_req = 1'b0; alloc_req = 1'b0;
        tick();
        chk("mg_write", 32'({wr_en, wr_addr, wr_data}),
            32'({1'b1, 6'd8, ent(6'h06, 10'h222, 2'b11)}));
        tick();
        chk("mg_once", 32'(wr_en), 32'd0);

        // Invalidate with a pending allocation outstanding.
        @(negedge CLK);
        upd_req = 1'b1; upd_idx = 6'd2;
        alloc_req = 1'b1; alloc_pc = 10'h073; alloc_is_jump = 1'b0;
        tick();
        @(negedge CLK);
        upd_req = 1'b0; alloc_req = 1'b0; inv_req = 1'b1;
        tick();
        chk("inv", 32'({ready, wr_en}), 32'd0);
        @(negedge CLK);
        inv_req = 1'b0;
        alloc_req = 1'b1; alloc_pc = 10'h093;
        sweep("inv_clr");
        tick();
        chk("inv_nopend", 32'(wr_en), 32'd0);
        @(negedge CLK);
        alloc_req = 1'b1; alloc_pc = 10'h083; alloc_target = 10'h0F0;
        tick();
        chk("inv_al", 32'({wr_en, wr_addr, wr_data}),
            32'({1'b1, 6'd12, ent(6'h08, 10'h0F0, 2'b10)}));
        @(negedge CLK);
        alloc_req = 1'b0;

        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            upd_req   = 1'b1;
            upd_idx   = 6'(32 + i);
            upd_entry = ent(6'h05, 10'h005, u_ctr[i]);
            upd_taken = u_tk[i];
            tick();
        end
`ifdef BHT_STATS_EN
        chk("stat_upd", 32'(stat_upd), 32'd5);
        chk("stat_mis", 32'(stat_mispred), 32'd2);
`endif
        chk("last_upd", 32'({wr_en, wr_addr}), 32'({1'b1, 6'd36}));
        rst = 1'b1;
        upd_req = 1'b0;
        #1;
        chk("rst_mid", 32'({wr_en, wr_addr, wr_data, ready, alloc_drop}), 32'd0);
`ifdef BHT_STATS_EN
        chk("stat_rst", 32'({stat_upd, stat_mispred}), 32'd0);
`endif
        @(negedge CLK);
        rst = 1'b0;
        tick();
        chk("rst_sweep", 32'({wr_en, wr_addr}), 32'({1'b1, 6'd0}));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
